// File: rtl/axis_pipeline_fifo_pkg.sv
// Shared derived constants for the pipelined AXI-Stream FIFO.
package axis_pipeline_fifo_pkg;

   // Buffer address width; pointers carry one extra wrap bit on top of this.
   function automatic int unsigned addr_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // Committed occupancy at which the head of the ready chain drops, leaving room for 2*LENGTH beats in flight.
   function automatic int unsigned pause_thresh(input int unsigned depth, input int unsigned length);
      return depth - 2 * length;
   endfunction

endpackage

// File: rtl/axis_pipeline_fifo_if.sv
// AXI4-Stream bus bundle with master/slave views.
interface axis_pipeline_fifo_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned KEEP_WIDTH = 1,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned DEST_WIDTH = 8,
   parameter int unsigned USER_WIDTH = 1
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [ID_WIDTH-1:0]   tid;
   logic [DEST_WIDTH-1:0] tdest;
   logic [USER_WIDTH-1:0] tuser;

   modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_pipeline_fifo_stages.sv
// Registered forward beat/valid chain and reverse ready chain, LENGTH stages each.
module axis_pipe_stages #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned LENGTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_beat_i,
   input  logic             pause_i,
   output logic             ready_o,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_beat_o
);
   logic [LENGTH-1:0] valid_q;
   logic [LENGTH-1:0] rdy_q;
   logic [WIDTH-1:0]  beat_q [LENGTH];

   // Valid and ready chains; the upstream sees only the tail of the ready chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         rdy_q   <= '0;
      end else begin
         valid_q[0] <= in_valid_i && rdy_q[LENGTH-1];
         rdy_q[0]   <= !pause_i;
         for (int i = 1; i < LENGTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            rdy_q[i]   <= rdy_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      beat_q[0] <= in_beat_i;
      for (int i = 1; i < LENGTH; i++) beat_q[i] <= beat_q[i-1];
   end

   assign ready_o     = rdy_q[LENGTH-1];
   assign out_valid_o = valid_q[LENGTH-1];
   assign out_beat_o  = beat_q[LENGTH-1];
endmodule

// File: rtl/axis_pipeline_fifo.sv
// AXI4-Stream FIFO with registered forward/reverse pipelines, optional store-and-forward and bad-frame drop.
module axis_pipeline_fifo
   import axis_pipeline_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter bit          KEEP_ENABLE    = (DATA_WIDTH > 8),
   parameter int unsigned KEEP_WIDTH     = (DATA_WIDTH + 7) / 8,
   parameter bit          LAST_ENABLE    = 1'b1,
   parameter bit          ID_ENABLE      = 1'b0,
   parameter int unsigned ID_WIDTH       = 8,
   parameter bit          DEST_ENABLE    = 1'b0,
   parameter int unsigned DEST_WIDTH     = 8,
   parameter bit          USER_ENABLE    = 1'b1,
   parameter int unsigned USER_WIDTH     = 1,
   parameter int unsigned LENGTH         = 2,
   parameter int unsigned DEPTH          = 32,
   parameter bit          FRAME_FIFO     = 1'b0,
   parameter bit          DROP_BAD_FRAME = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   axis_pipeline_fifo_if.slave      s_axis,
   axis_pipeline_fifo_if.master     m_axis,
   output logic [$clog2(DEPTH):0]   status_depth,
   output logic                     status_overflow,
   output logic                     status_bad_frame,
   output logic                     status_good_frame
);
   localparam int unsigned AW       = addr_width(DEPTH);
   localparam int unsigned PW       = AW + 1;
   localparam int unsigned THRESH   = pause_thresh(DEPTH, LENGTH);
   localparam int unsigned BW       = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
   localparam int unsigned LAST_BIT = USER_WIDTH + DEST_WIDTH + ID_WIDTH;

   logic [BW-1:0] in_beat, wr_beat, out_q, out_d;
   logic [BW-1:0] mem_q [DEPTH];
   logic          wr_valid, wr_last, wr_bad, pause, full, empty, mem_we;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_cur_q, wr_cur_d, rd_ptr_q, rd_ptr_d, occ, depth_q;
   logic          drop_q, drop_d, m_valid_q, m_valid_d;
   logic          ovf_q, ovf_d, bad_q, bad_d, good_q, good_d;

   assign in_beat = {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tid, s_axis.tdest, s_axis.tuser};

   axis_pipe_stages #(.WIDTH(BW), .LENGTH(LENGTH)) u_stages (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (s_axis.tvalid),
      .in_beat_i   (in_beat),
      .pause_i     (pause),
      .ready_o     (s_axis.tready),
      .out_valid_o (wr_valid),
      .out_beat_o  (wr_beat)
   );

   assign occ     = wr_ptr_q - rd_ptr_q;
   assign pause   = occ >= PW'(THRESH);
   assign full    = wr_cur_q == (rd_ptr_q ^ {1'b1, {AW{1'b0}}});
   assign empty   = wr_ptr_q == rd_ptr_q;
   assign wr_last = LAST_ENABLE ? wr_beat[LAST_BIT] : 1'b1;
   assign wr_bad  = wr_beat[0];

   // Write-side frame handling and read-side output register.
   always_comb begin
      wr_cur_d  = wr_cur_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      drop_d    = drop_q;
      mem_we    = 1'b0;
      ovf_d     = 1'b0;
      bad_d     = 1'b0;
      good_d    = 1'b0;
      out_d     = out_q;
      m_valid_d = m_valid_q && !m_axis.tready;

      if (wr_valid) begin
         if (!FRAME_FIFO) begin
            if (!full) begin
               mem_we   = 1'b1;
               wr_cur_d = wr_cur_q + PW'(1);
               wr_ptr_d = wr_cur_q + PW'(1);
            end else begin
               ovf_d = 1'b1;
            end
         end else if (drop_q || full) begin
            // Frame no longer fits: swallow the rest and rewind to the last commit.
            drop_d = 1'b1;
            if (wr_last) begin
               wr_cur_d = wr_ptr_q;
               drop_d   = 1'b0;
               ovf_d    = 1'b1;
            end
         end else begin
            mem_we   = 1'b1;
            wr_cur_d = wr_cur_q + PW'(1);
            if (wr_last) begin
               if (DROP_BAD_FRAME && wr_bad) begin
                  wr_cur_d = wr_ptr_q;
                  bad_d    = 1'b1;
               end else begin
                  wr_ptr_d = wr_cur_q + PW'(1);
                  good_d   = 1'b1;
               end
            end
         end
      end

      if (!empty && (!m_valid_q || m_axis.tready)) begin
         out_d     = mem_q[rd_ptr_q[AW-1:0]];
         m_valid_d = 1'b1;
         rd_ptr_d  = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         wr_cur_q  <= '0;
         rd_ptr_q  <= '0;
         drop_q    <= 1'b0;
         m_valid_q <= 1'b0;
         ovf_q     <= 1'b0;
         bad_q     <= 1'b0;
         good_q    <= 1'b0;
         depth_q   <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         wr_cur_q  <= wr_cur_d;
         rd_ptr_q  <= rd_ptr_d;
         drop_q    <= drop_d;
         m_valid_q <= m_valid_d;
         ovf_q     <= ovf_d;
         bad_q     <= bad_d;
         good_q    <= good_d;
         depth_q   <= wr_ptr_d - rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_cur_q[AW-1:0]] <= wr_beat;
      out_q <= out_d;
   end

   logic [DATA_WIDTH-1:0] o_data;
   logic [KEEP_WIDTH-1:0] o_keep;
   logic                  o_last;
   logic [ID_WIDTH-1:0]   o_id;
   logic [DEST_WIDTH-1:0] o_dest;
   logic [USER_WIDTH-1:0] o_user;

   assign {o_data, o_keep, o_last, o_id, o_dest, o_user} = out_q;

   // Disabled sideband fields present their fixed values.
   assign m_axis.tvalid = m_valid_q;
   assign m_axis.tdata  = o_data;
   assign m_axis.tkeep  = KEEP_ENABLE ? o_keep : {KEEP_WIDTH{1'b1}};
   assign m_axis.tlast  = LAST_ENABLE ? o_last : 1'b1;
   assign m_axis.tid    = ID_ENABLE   ? o_id   : '0;
   assign m_axis.tdest  = DEST_ENABLE ? o_dest : '0;
   assign m_axis.tuser  = USER_ENABLE ? o_user : '0;

   assign status_depth      = depth_q;
   assign status_overflow   = ovf_q;
   assign status_bad_frame  = bad_q;
   assign status_good_frame = good_q;
endmodule

// File: tb/tb_axis_pipeline_fifo.sv
// Directed bench: streaming instance (a) and frame/drop-bad instance (b), both LENGTH=2, DEPTH=32.
module tb_axis_pipeline_fifo;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axis_pipeline_fifo_if a_s ();
   axis_pipeline_fifo_if a_m ();
   axis_pipeline_fifo_if b_s ();
   axis_pipeline_fifo_if b_m ();

   logic [5:0] a_depth, b_depth;
   logic       a_ovf, a_bad, a_good, b_ovf_o, b_bad_o, b_good_o;

   axis_pipeline_fifo #(.LENGTH(2), .DEPTH(32), .FRAME_FIFO(1'b0)) dut_a (
      .clk(clk), .rst(rst), .s_axis(a_s), .m_axis(a_m),
      .status_depth(a_depth), .status_overflow(a_ovf),
      .status_bad_frame(a_bad), .status_good_frame(a_good));

   axis_pipeline_fifo #(.LENGTH(2), .DEPTH(32), .FRAME_FIFO(1'b1), .DROP_BAD_FRAME(1'b1)) dut_b (
      .clk(clk), .rst(rst), .s_axis(b_s), .m_axis(b_m),
      .status_depth(b_depth), .status_overflow(b_ovf_o),
      .status_bad_frame(b_bad_o), .status_good_frame(b_good_o));

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   logic [8:0] b_out[$];
   int         b_out_cyc[$];
   int         b_good = 0, b_bad = 0, b_ovf = 0, b_last_good_cyc = -1;

   // Record every beat and status pulse of instance b.
   always @(negedge clk) begin
      cyc++;
      if (b_m.tvalid && b_m.tready) begin
         b_out.push_back({b_m.tlast, b_m.tdata});
         b_out_cyc.push_back(cyc);
      end
      if (b_good_o) begin b_good++; b_last_good_cyc = cyc; end
      if (b_bad_o) b_bad++;
      if (b_ovf_o) b_ovf++;
   end

   task automatic send_b(input int n, input int base, input bit bad, input int gap);
      int t;
      for (int i = 0; i < n; i++) begin
         if (i == n - 1 && gap > 0) begin
            b_s.tvalid = 1'b0;
            repeat (gap) @(negedge clk);
         end
         b_s.tvalid = 1'b1;
         b_s.tdata  = 8'(base + i);
         b_s.tlast  = (i == n - 1);
         b_s.tuser  = 1'(bad && (i == n - 1));
         t = 0;
         while (b_s.tready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
         if (t >= 100) begin
            $display("FAIL send_b_tready: got %b required 1", b_s.tready);
            n_err++; n_cmp++;
         end
         @(posedge clk);
         @(negedge clk);
      end
      b_s.tvalid = 1'b0;
      b_s.tlast  = 1'b0;
      b_s.tuser  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      if (a_m.tvalid !== 1'b0) begin $display("FAIL rst_m_tvalid: got %b required 0", a_m.tvalid); n_err++; end n_cmp++;
      if (a_depth !== 6'd0) begin $display("FAIL rst_depth: got %0d required 0", a_depth); n_err++; end n_cmp++;
      if ({a_ovf, a_bad, a_good} !== 3'b000) begin $display("FAIL rst_pulses: got %b required 000", {a_ovf, a_bad, a_good}); n_err++; end n_cmp++;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (a_s.tready !== 1'(k == 2)) begin $display("FAIL rel_tready_%0d: got %b required %b", k, a_s.tready, (k == 2)); n_err++; end n_cmp++;
         if (k < 2) @(negedge clk);
      end
      if (b_s.tready !== 1'b1) begin $display("FAIL rel_b_tready: got %b required 1", b_s.tready); n_err++; end n_cmp++;
   endtask

   task automatic test_single_beat();
      a_s.tvalid = 1'b1;
      a_s.tdata  = 8'hA5;
      a_s.tlast  = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0) a_s.tvalid = 1'b0;
         if (a_m.tvalid !== 1'(k == 3)) begin $display("FAIL single_tvalid_e%0d: got %b required %b", k, a_m.tvalid, (k == 3)); n_err++; end n_cmp++;
         if (k == 3) begin
            if (a_m.tdata !== 8'hA5) begin $display("FAIL single_tdata: got %h required a5", a_m.tdata); n_err++; end n_cmp++;
            if (a_m.tlast !== 1'b1) begin $display("FAIL single_tlast: got %b required 1", a_m.tlast); n_err++; end n_cmp++;
         end
      end
      if (a_depth !== 6'd0) begin $display("FAIL single_depth: got %0d required 0", a_depth); n_err++; end n_cmp++;
      a_s.tlast = 1'b0;
   endtask

   task automatic test_fill_drain();
      int sent = 0, got = 0, peak = 0, ovf = 0, bad_order = 0;
      bit acc_in, acc_out;
      logic [7:0] seen;
      a_m.tready = 1'b0;
      for (int c = 0; c < 150; c++) begin
         a_s.tvalid = (sent < 100);
         a_s.tdata  = 8'(sent);
         acc_in = a_s.tvalid && a_s.tready;
         if (int'(a_depth) > peak) peak = int'(a_depth);
         if (a_ovf) ovf++;
         @(posedge clk);
         if (acc_in) sent++;
         @(negedge clk);
      end
      if (a_s.tready !== 1'b0) begin $display("FAIL fill_tready: got %b required 0", a_s.tready); n_err++; end n_cmp++;
      if (peak !== 32) begin $display("FAIL fill_peak_depth: got %0d required 32", peak); n_err++; end n_cmp++;
      if (sent !== 33) begin $display("FAIL fill_accepted: got %0d required 33", sent); n_err++; end n_cmp++;
      if (a_m.tvalid !== 1'b1 || a_m.tdata !== 8'h00) begin $display("FAIL fill_head: got %b/%h required 1/00", a_m.tvalid, a_m.tdata); n_err++; end n_cmp++;
      a_m.tready = 1'b1;
      for (int c = 0; c < 600 && got < 100; c++) begin
         a_s.tvalid = (sent < 100);
         a_s.tdata  = 8'(sent);
         acc_in  = a_s.tvalid && a_s.tready;
         acc_out = a_m.tvalid && a_m.tready;
         seen    = a_m.tdata;
         if (a_ovf) ovf++;
         @(posedge clk);
         if (acc_in) sent++;
         if (acc_out) begin
            if (seen !== 8'(got)) begin
               if (bad_order < 5) $display("FAIL drain_order_%0d: got %h required %h", got, seen, 8'(got));
               bad_order++;
            end
            got++;
         end
         @(negedge clk);
      end
      a_s.tvalid = 1'b0;
      if (bad_order != 0) n_err++; n_cmp++;
      if (got !== 100) begin $display("FAIL drain_count: got %0d required 100", got); n_err++; end n_cmp++;
      if (ovf !== 0) begin $display("FAIL fill_overflow: got %0d required 0", ovf); n_err++; end n_cmp++;
      repeat (4) @(negedge clk);
      if (a_depth !== 6'd0 || a_m.tvalid !== 1'b0) begin $display("FAIL drain_end: got depth %0d tvalid %b required 0/0", a_depth, a_m.tvalid); n_err++; end n_cmp++;
   endtask

   task automatic test_frame_gap();
      int n0 = b_out.size(), g0 = b_good;
      logic [8:0] exp;
      send_b(4, 1, 1'b0, 10);
      repeat (10) @(negedge clk);
      if (b_good - g0 !== 1) begin $display("FAIL frame_good_pulses: got %0d required 1", b_good - g0); n_err++; end n_cmp++;
      if (b_out.size() - n0 !== 4) begin $display("FAIL frame_beats: got %0d required 4", b_out.size() - n0); n_err++; end
      else begin
         for (int i = 0; i < 4; i++) begin
            exp = {1'(i == 3), 8'(1 + i)};
            if (b_out[n0+i] !== exp) begin $display("FAIL frame_beat_%0d: got %h required %h", i, b_out[n0+i], exp); n_err++; end n_cmp++;
         end
         if (b_out_cyc[n0] !== b_last_good_cyc + 1) begin $display("FAIL frame_first_cycle: got %0d required %0d", b_out_cyc[n0], b_last_good_cyc + 1); n_err++; end
      end
      n_cmp++;
   endtask

   task automatic test_bad_frame();
      int n0 = b_out.size(), g0 = b_good, bd0 = b_bad;
      send_b(3, 'h10, 1'b1, 0);
      send_b(2, 'h20, 1'b0, 0);
      repeat (10) @(negedge clk);
      if (b_bad - bd0 !== 1) begin $display("FAIL bad_pulses: got %0d required 1", b_bad - bd0); n_err++; end n_cmp++;
      if (b_good - g0 !== 1) begin $display("FAIL bad_good_pulses: got %0d required 1", b_good - g0); n_err++; end n_cmp++;
      if (b_out.size() - n0 !== 2) begin $display("FAIL bad_beats: got %0d required 2", b_out.size() - n0); n_err++; end
      else if (b_out[n0] !== 9'h020 || b_out[n0+1] !== 9'h121) begin
         $display("FAIL bad_payload: got %h %h required 020 121", b_out[n0], b_out[n0+1]); n_err++;
      end
      n_cmp++;
      if (b_depth !== 6'd0) begin $display("FAIL bad_depth: got %0d required 0", b_depth); n_err++; end n_cmp++;
   endtask

   task automatic test_overflow_reset();
      int n0 = b_out.size(), g0 = b_good, o0 = b_ovf, t;
      send_b(40, 0, 1'b0, 0);
      repeat (10) @(negedge clk);
      if (b_ovf - o0 !== 1) begin $display("FAIL long_overflow: got %0d required 1", b_ovf - o0); n_err++; end n_cmp++;
      if (b_out.size() - n0 !== 0) begin $display("FAIL long_beats: got %0d required 0", b_out.size() - n0); n_err++; end n_cmp++;
      if (b_good - g0 !== 0) begin $display("FAIL long_good: got %0d required 0", b_good - g0); n_err++; end n_cmp++;
      b_s.tvalid = 1'b1;
      b_s.tlast  = 1'b0;
      b_s.tdata  = 8'h77;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      b_s.tvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      if (b_s.tready !== 1'b0) begin $display("FAIL rst2_tready: got %b required 0", b_s.tready); n_err++; end n_cmp++;
      t = 0;
      while (b_s.tready !== 1'b1 && t < 10) begin @(negedge clk); t++; end
      if (t !== 2) begin $display("FAIL rst2_recover_cycles: got %0d required 2", t); n_err++; end n_cmp++;
      n0 = b_out.size(); g0 = b_good; o0 = b_ovf;
      send_b(2, 'h50, 1'b0, 0);
      repeat (10) @(negedge clk);
      if (b_out.size() - n0 !== 2) begin $display("FAIL post_rst_beats: got %0d required 2", b_out.size() - n0); n_err++; end
      else if (b_out[n0] !== 9'h050 || b_out[n0+1] !== 9'h151) begin
         $display("FAIL post_rst_payload: got %h %h required 050 151", b_out[n0], b_out[n0+1]); n_err++;
      end
      n_cmp++;
      if (b_good - g0 !== 1 || b_ovf - o0 !== 0) begin $display("FAIL post_rst_pulses: got good %0d ovf %0d required 1/0", b_good - g0, b_ovf - o0); n_err++; end n_cmp++;
      if (b_depth !== 6'd0) begin $display("FAIL post_rst_depth: got %0d required 0", b_depth); n_err++; end n_cmp++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      a_s.tvalid = 1'b0; a_s.tdata = '0; a_s.tkeep = 1'b1; a_s.tlast = 1'b0;
      a_s.tid = '0; a_s.tdest = '0; a_s.tuser = '0; a_m.tready = 1'b1;
      b_s.tvalid = 1'b0; b_s.tdata = '0; b_s.tkeep = 1'b1; b_s.tlast = 1'b0;
      b_s.tid = '0; b_s.tdest = '0; b_s.tuser = '0; b_m.tready = 1'b1;
      @(negedge clk);
      test_reset();
      test_single_beat();
      test_fill_drain();
      test_frame_gap();
      test_bad_frame();
      test_overflow_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/axis_pipeline_fifo.md
Name: axis_pipeline_fifo

Overview:
AXI4-Stream FIFO for long or retimed paths. A configurable number of register stages carries data forward and tready backward, so no combinational path crosses the pipeline. A sized elastic buffer absorbs in-flight beats and feeds a registered output stage. Adds a store-and-forward frame mode, bad-frame dropping, an occupancy output and event pulses.

Parameters:
DATA_WIDTH, 8, tdata width in bits
KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep; when 0, m_axis_tkeep is all ones
KEEP_WIDTH, (DATA_WIDTH+7)/8, tkeep width
LAST_ENABLE, 1, propagate tlast; when 0, m_axis_tlast=1
ID_ENABLE, 0, propagate tid; when 0, output is 0
ID_WIDTH, 8, tid width
DEST_ENABLE, 0, propagate tdest; when 0, output is 0
DEST_WIDTH, 8, tdest width
USER_ENABLE, 1, propagate tuser; when 0, output is 0
USER_WIDTH, 1, tuser width
LENGTH, 2, forward and reverse pipeline stages; must be >=1
DEPTH, 32, buffer entries; power of two; must be >2*LENGTH+1
FRAME_FIFO, 0, 1 = output only whole frames (requires LAST_ENABLE)
DROP_BAD_FRAME, 0, 1 = discard frames with tuser[0]=1 on tlast (requires FRAME_FIFO and USER_ENABLE)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_axis_tdata/tkeep/tvalid/tready(out)/tlast/tid/tdest/tuser  in  per params  AXI-S slave
m_axis_tdata/tkeep/tvalid/tready(in)/tlast/tid/tdest/tuser  out  per params  AXI-S master
status_depth  out  $clog2(DEPTH)+1  committed occupancy (wr_ptr-rd_ptr)
status_overflow  out  1  one-cycle pulse: beat or frame lost to a full buffer
status_bad_frame  out  1  one-cycle pulse: bad frame discarded
status_good_frame  out  1  one-cycle pulse: frame committed (FRAME_FIFO only)

Behaviour:
- Reset (rst=1 at a clock edge):
  - All pipeline valid and ready regs clear to 0.
  - Pointers clear to 0; drop flag clears.
  - m_axis_tvalid=0, all status pulses 0, status_depth=0.
  - Reset mid-frame discards the partial frame.
- Forward chain:
  - Stage0 valid <= s_tvalid && s_tready; sideband always copied.
  - Each edge, stage i moves to stage i+1.
  - Stage LENGTH-1 is the buffer write port.
- Reverse chain:
  - LENGTH regs; the head loads !pause.
  - s_axis_tready = tail reg. It stays 0 for LENGTH cycles after reset release.
- pause = (wr_ptr - rd_ptr) >= DEPTH-2*LENGTH, computed on committed pointers. This reserves headroom for 2*LENGTH beats in flight.
- Pointers are ADDR_WIDTH+1 bits wide (ADDR_WIDTH=$clog2(DEPTH)); the MSB distinguishes full from empty.
  - full = wr_cur == rd_ptr ^ (1<<ADDR_WIDTH)
  - empty = wr_ptr == rd_ptr
- Write when FRAME_FIFO=0:
  - A valid beat at the write port is stored if !full; wr_cur and wr_ptr increment together.
  - A beat arriving when full is dropped and status_overflow pulses (unreachable under normal handshakes).
- Write when FRAME_FIFO=1:
  - Beats write at wr_cur only. On tlast, wr_ptr <= wr_cur+1 (commit) and status_good_frame pulses.
  - If full occurs mid-frame, set drop. While drop is set, discard beats through tlast. On that tlast, wr_cur <= wr_ptr, clear drop, pulse status_overflow.
  - A frame longer than DEPTH is therefore always dropped and cannot deadlock.
  - If DROP_BAD_FRAME=1 and tlast carries tuser[0]=1: wr_cur <= wr_ptr, pulse status_bad_frame, no commit.
- Read:
  - If !empty && (!m_tvalid || m_tready), the output register loads entry rd_ptr, m_tvalid <= 1 and rd_ptr increments.
  - Otherwise, m_tvalid <= m_tvalid && !m_tready.
  - Simultaneous read and write are both performed.
- Latency:
  - Normal mode: a beat accepted at edge E drives m_tvalid after edge E+LENGTH+1.
  - Frame mode: the first beat appears the cycle after the commit edge.
- Ordering is preserved. Sideband fields are stored per beat.

Decomposition:
- Package axis_pipeline_fifo_pkg holds the derived-constant functions: addr_width(DEPTH) and pause_thresh(DEPTH,LENGTH)=DEPTH-2*LENGTH.
- Sub-module axis_pipe_stages: the LENGTH-deep forward data/valid chain plus the reverse ready chain. It is instantiated once.
- Buffer, frame logic and output register stay in the top module.

Test Plan:
1. LENGTH=2, reset release -> s_tready=0 for 2 cycles, then 1; m_tvalid=0; status_depth=0.
2. Single beat 0xA5 with tlast, m_tready=1 -> m_tdata=0xA5 with tvalid exactly 3 cycles after acceptance; status_depth returns to 0.
3. DEPTH=32, m_tready=0, beats 0..99 offered continuously -> s_tready falls; status_depth peaks <=32; no overflow. Then m_tready=1 -> 0..99 emerge in order, no gaps in tdata.
4. FRAME_FIFO=1, 4-beat frame with a 10-cycle gap before tlast -> m_tvalid stays 0 until the commit; one good_frame pulse; 4 beats out with tlast on the 4th.
5. DROP_BAD_FRAME=1: frame A (3 beats, tuser=1 on tlast), then frame B (2 beats) -> one bad_frame pulse; only B is output; status_depth ends at 0.
6. FRAME_FIFO=1, DEPTH=32, 40-beat frame then rst mid-way through a second frame -> overflow pulse on the first tlast; no output; after reset s_tready recovers and a 2-beat frame passes intact.
